// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with a LEAD-tick lookahead request stage.
// Optional free-running frame counter is built when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LEAD     = 1,
  parameter int CW       = 12
) (
  input  logic          vga_clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic          req,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_END = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_END = CW'(V_SYNC);
  localparam logic [CW-1:0] HA0    = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] VA0    = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] HA_END = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] VA_END = CW'(V_SYNC + V_BP + V_ACTIVE);

  // Everything that must stay aligned with the pixel travels as one bundle.
  typedef struct packed {
    logic          act;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic          hs;
    logic          vs;
    logic          ls;
    logic          fs;
  } stage_t;

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  stage_t        dec;
  stage_t        rq;
  stage_t        tail;

  always_ff @(posedge vga_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    // NOTE: default every field first so no path through this block can infer a latch.
    dec    = '0;
    dec.hs = (h_cnt < HS_END);
    dec.vs = (v_cnt < VS_END);
    dec.ls = (h_cnt == '0);
    dec.fs = (h_cnt == '0) && (v_cnt == '0);
    if ((h_cnt >= HA0) && (h_cnt < HA_END) && (v_cnt >= VA0) && (v_cnt < VA_END)) begin
      dec.act = 1'b1;
      dec.px  = h_cnt - HA0;
      dec.py  = v_cnt - VA0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      rq <= '0;
    end else if (pix_en) begin
      rq <= dec;
    end
  end

  generate
    if (LEAD == 0) begin : g_no_lead
      assign tail = rq;
    end else begin : g_lead
      stage_t pipe [LEAD];

      always_ff @(posedge vga_clk) begin
        // NOTE: this small array is reset because its tail drives the pins directly.
        if (rst) begin
          for (int i = 0; i < LEAD; i++) pipe[i] <= '0;
        end else if (pix_en) begin
          pipe[0] <= rq;
          for (int i = 1; i < LEAD; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign tail = pipe[LEAD-1];
    end
  endgenerate

  assign req         = rq.act;
  assign req_x       = rq.px;
  assign req_y       = rq.py;
  assign de          = tail.act;
  assign x           = tail.px;
  assign y           = tail.py;
  assign hsync       = ~(tail.hs ^ HS_POL);
  assign vsync       = ~(tail.vs ^ VS_POL);
  // Pulses are qualified so a stalled pixel clock never sees a repeated strobe.
  assign line_start  = tail.ls & pix_en;
  assign frame_start = tail.fs & pix_en;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_q;

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      frame_q <= '0;
    end else if (frame_start) begin
      frame_q <= frame_q + 16'd1;
    end
  end

  assign frame_cnt = frame_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: small timing at LEAD 0/1/3 plus the default 640x480 build.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        act;
    logic [11:0] px;
    logic [11:0] py;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } exp_t;

  logic vga_clk;
  logic rst;
  logic pix_en;

  logic        req_s0, req_s1, req_s3, req_b;
  logic [11:0] rx_s0, rx_s1, rx_s3, rx_b;
  logic [11:0] ry_s0, ry_s1, ry_s3, ry_b;
  logic        hs_s0, hs_s1, hs_s3, hs_b;
  logic        vs_s0, vs_s1, vs_s3, vs_b;
  logic        de_s0, de_s1, de_s3, de_b;
  logic [11:0] x_s0, x_s1, x_s3, x_b;
  logic [11:0] y_s0, y_s1, y_s3, y_b;
  logic        ls_s0, ls_s1, ls_s3, ls_b;
  logic        fs_s0, fs_s1, fs_s3, fs_b;
  logic [15:0] fc_s0, fc_s1, fc_s3, fc_b;

  int checks = 0;
  int passed = 0;
  int n = 0;
  exp_t hist_s[$];
  exp_t hist_b[$];
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] exp_fc = '0;
`endif

  int          obs_n;
  logic        o1_req, o1_de, o1_hs, o1_vs, o1_ls, o1_fs;
  logic [11:0] o1_x, o1_y;
  logic [15:0] o1_fc;
  logic        o0_de, o0_fs;
  logic        o3_req, o3_de, o3_ls, o3_fs;
  logic        ob_de, ob_hs, ob_vs;
  logic [11:0] ob_x, ob_y;

  vga_timing_gen #(.H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
                   .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1), .LEAD(0)) dut_s0 (
    .vga_clk(vga_clk), .rst(rst), .pix_en(pix_en), .req(req_s0), .req_x(rx_s0), .req_y(ry_s0),
    .hsync(hs_s0), .vsync(vs_s0), .de(de_s0), .x(x_s0), .y(y_s0),
    .line_start(ls_s0), .frame_start(fs_s0), .frame_cnt(fc_s0));

  vga_timing_gen #(.H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
                   .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1), .LEAD(1)) dut_s1 (
    .vga_clk(vga_clk), .rst(rst), .pix_en(pix_en), .req(req_s1), .req_x(rx_s1), .req_y(ry_s1),
    .hsync(hs_s1), .vsync(vs_s1), .de(de_s1), .x(x_s1), .y(y_s1),
    .line_start(ls_s1), .frame_start(fs_s1), .frame_cnt(fc_s1));

  vga_timing_gen #(.H_SYNC(2), .H_BP(1), .H_ACTIVE(4), .H_FP(1),
                   .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1), .LEAD(3)) dut_s3 (
    .vga_clk(vga_clk), .rst(rst), .pix_en(pix_en), .req(req_s3), .req_x(rx_s3), .req_y(ry_s3),
    .hsync(hs_s3), .vsync(vs_s3), .de(de_s3), .x(x_s3), .y(y_s3),
    .line_start(ls_s3), .frame_start(fs_s3), .frame_cnt(fc_s3));

  vga_timing_gen dut_big (
    .vga_clk(vga_clk), .rst(rst), .pix_en(pix_en), .req(req_b), .req_x(rx_b), .req_y(ry_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b));

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference decode of raster position pos (ticks since reset) by division, not counters.
  function automatic exp_t decode(input int pos, input bit big);
    int hsw, hbp, ha, hfp, vsw, vbp, va, vfp, htot, vtot, h, v;
    exp_t e;
    if (big) begin
      hsw = 96; hbp = 48; ha = 640; hfp = 16; vsw = 2; vbp = 33; va = 480; vfp = 10;
    end else begin
      hsw = 2; hbp = 1; ha = 4; hfp = 1; vsw = 1; vbp = 1; va = 3; vfp = 1;
    end
    htot = hsw + hbp + ha + hfp;
    vtot = vsw + vbp + va + vfp;
    h = pos % htot;
    v = (pos / htot) % vtot;
    e = '0;
    e.hs = (h < hsw);
    e.vs = (v < vsw);
    e.ls = (h == 0);
    e.fs = (h == 0) && (v == 0);
    if (h >= hsw + hbp && h < hsw + hbp + ha && v >= vsw + vbp && v < vsw + vbp + va) begin
      e.act = 1'b1;
      e.px  = 12'(h - hsw - hbp);
      e.py  = 12'(v - vsw - vbp);
    end
    return e;
  endfunction

  function automatic exp_t lag(input int l, input bit big);
    exp_t z;
    z = '0;
    if (big) begin
      if (hist_b.size() > l) z = hist_b[hist_b.size() - 1 - l];
    end else begin
      if (hist_s.size() > l) z = hist_s[hist_s.size() - 1 - l];
    end
    return z;
  endfunction

  function automatic logic [53:0] pack(input exp_t r, input exp_t o, input bit en);
    return {r.act, r.px, r.py, o.act, o.px, o.py, !o.hs, !o.vs, o.ls & en, o.fs & en};
  endfunction

  // One clock cycle: drive inputs, compare all instances mid-cycle, then advance the model.
  task automatic step(input bit en, input bit r);
    exp_t s_rq, s_o1, s_o3, b_rq, b_o1;
    logic [53:0] e, a;
    logic [15:0] fc_want;
    rst    = r;
    pix_en = en;
    s_rq = lag(0, 1'b0);
    s_o1 = lag(1, 1'b0);
    s_o3 = lag(3, 1'b0);
    b_rq = lag(0, 1'b1);
    b_o1 = lag(1, 1'b1);
    @(negedge vga_clk);
    obs_n = n;
    o1_req = req_s1; o1_de = de_s1; o1_x = x_s1; o1_y = y_s1; o1_hs = hs_s1; o1_vs = vs_s1;
    o1_ls = ls_s1; o1_fs = fs_s1; o1_fc = fc_s1;
    o0_de = de_s0; o0_fs = fs_s0;
    o3_req = req_s3; o3_de = de_s3; o3_ls = ls_s3; o3_fs = fs_s3;
    ob_de = de_b; ob_x = x_b; ob_y = y_b; ob_hs = hs_b; ob_vs = vs_b;

    e = pack(s_rq, s_rq, en);
    a = {req_s0, rx_s0, ry_s0, de_s0, x_s0, y_s0, hs_s0, vs_s0, ls_s0, fs_s0};
    checks++;
    if (a !== e) $display("FAIL sb_lead0 n=%0d actual=%h required=%h", n, a, e);
    else passed++;

    e = pack(s_rq, s_o1, en);
    a = {req_s1, rx_s1, ry_s1, de_s1, x_s1, y_s1, hs_s1, vs_s1, ls_s1, fs_s1};
    checks++;
    if (a !== e) $display("FAIL sb_lead1 n=%0d actual=%h required=%h", n, a, e);
    else passed++;

    e = pack(s_rq, s_o3, en);
    a = {req_s3, rx_s3, ry_s3, de_s3, x_s3, y_s3, hs_s3, vs_s3, ls_s3, fs_s3};
    checks++;
    if (a !== e) $display("FAIL sb_lead3 n=%0d actual=%h required=%h", n, a, e);
    else passed++;

    e = pack(b_rq, b_o1, en);
    a = {req_b, rx_b, ry_b, de_b, x_b, y_b, hs_b, vs_b, ls_b, fs_b};
    checks++;
    if (a !== e) $display("FAIL sb_default n=%0d actual=%h required=%h", n, a, e);
    else passed++;

`ifdef VGA_FRAME_CNT_EN
    fc_want = exp_fc;
`else
    fc_want = 16'd0;
`endif
    checks++;
    if (fc_s1 !== fc_want) $display("FAIL sb_frame_cnt n=%0d actual=%0d required=%0d", n, fc_s1, fc_want);
    else passed++;

    @(posedge vga_clk);
    #1;
    if (r) begin
      hist_s.delete();
      hist_b.delete();
      n = 0;
`ifdef VGA_FRAME_CNT_EN
      exp_fc = '0;
`endif
    end else if (en) begin
`ifdef VGA_FRAME_CNT_EN
      if (s_o1.fs) exp_fc = exp_fc + 16'd1;
`endif
      hist_s.push_back(decode(n, 1'b0));
      hist_b.push_back(decode(n, 1'b1));
      n++;
      if (hist_s.size() > 5) void'(hist_s.pop_front());
      if (hist_b.size() > 5) void'(hist_b.pop_front());
    end
  endtask

  task automatic test_reset();
    logic [69:0] want;
    want = {1'b0, 12'd0, 12'd0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    rst    = 1'b1;
    pix_en = 1'b1;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    checks++;
    if ({req_s1, rx_s1, ry_s1, de_s1, x_s1, y_s1, hs_s1, vs_s1, ls_s1, fs_s1, fc_s1} !== want)
      $display("FAIL reset_lead1 actual=%h required=%h",
               {req_s1, rx_s1, ry_s1, de_s1, x_s1, y_s1, hs_s1, vs_s1, ls_s1, fs_s1, fc_s1}, want);
    else passed++;
    checks++;
    if ({req_s3, rx_s3, ry_s3, de_s3, x_s3, y_s3, hs_s3, vs_s3, ls_s3, fs_s3, fc_s3} !== want)
      $display("FAIL reset_lead3 actual=%h required=%h",
               {req_s3, rx_s3, ry_s3, de_s3, x_s3, y_s3, hs_s3, vs_s3, ls_s3, fs_s3, fc_s3}, want);
    else passed++;
    checks++;
    if ({req_b, rx_b, ry_b, de_b, x_b, y_b, hs_b, vs_b, ls_b, fs_b, fc_b} !== want)
      $display("FAIL reset_default actual=%h required=%h",
               {req_b, rx_b, ry_b, de_b, x_b, y_b, hs_b, vs_b, ls_b, fs_b, fc_b}, want);
    else passed++;
    @(posedge vga_clk);
    #1;
    hist_s.delete();
    hist_b.delete();
    n = 0;
  endtask

  task automatic test_small_run();
    int first_req1 = -1, first_req3 = -1, first_de0 = -1, first_de1 = -1, first_de3 = -1;
    int req_cnt = 0;
    logic [11:0] x0 = '1, y0 = '1;
    logic [15:0] fc_want;
    step(1'b1, 1'b1);
    for (int k = 0; k < 150; k++) begin
      step(1'b1, 1'b0);
      if (o1_req && first_req1 < 0) first_req1 = obs_n;
      if (o3_req && first_req3 < 0) first_req3 = obs_n;
      if (o0_de && first_de0 < 0) first_de0 = obs_n;
      if (o3_de && first_de3 < 0) first_de3 = obs_n;
      if (o1_de && first_de1 < 0) begin
        first_de1 = obs_n;
        x0 = o1_x;
        y0 = o1_y;
      end
      if (o1_req && obs_n >= 1 && obs_n <= 48) req_cnt++;
      if (obs_n == 3 || obs_n == 51 || obs_n == 99) begin
`ifdef VGA_FRAME_CNT_EN
        fc_want = 16'((obs_n - 3) / 48 + 1);
`else
        fc_want = 16'd0;
`endif
        checks++;
        if (o1_fc !== fc_want) $display("FAIL frame_cnt_seq n=%0d actual=%0d required=%0d", obs_n, o1_fc, fc_want);
        else passed++;
      end
    end
    checks++;
    if (first_req1 !== 20) $display("FAIL first_req_tick actual=%0d required=20", first_req1);
    else passed++;
    checks++;
    if (req_cnt !== 12) $display("FAIL req_per_frame actual=%0d required=12", req_cnt);
    else passed++;
    checks++;
    if (first_de1 !== 21 || x0 !== 12'd0 || y0 !== 12'd0)
      $display("FAIL first_de_lead1 tick=%0d x=%0d y=%0d required tick=21 x=0 y=0", first_de1, x0, y0);
    else passed++;
    checks++;
    if (first_de0 !== 20) $display("FAIL first_de_lead0 actual=%0d required=20", first_de0);
    else passed++;
    checks++;
    if (first_de3 !== 23) $display("FAIL first_de_lead3 actual=%0d required=23", first_de3);
    else passed++;
    checks++;
    if (first_req3 !== 20) $display("FAIL first_req_lead3 actual=%0d required=20", first_req3);
    else passed++;
  endtask

  task automatic test_pix_en_toggle();
    int first_req = -1;
    int req_cnt = 0;
    bit en;
    step(1'b1, 1'b1);
    for (int k = 0; k < 200; k++) begin
      en = (k % 2 == 0);
      step(en, 1'b0);
      if (!en) begin
        checks++;
        if ({o1_ls, o1_fs, o3_ls, o3_fs, o0_fs} !== 5'b0)
          $display("FAIL pulse_while_stalled n=%0d actual=%b required=00000", obs_n, {o1_ls, o1_fs, o3_ls, o3_fs, o0_fs});
        else passed++;
      end else begin
        if (o1_req && first_req < 0) first_req = obs_n;
        if (o1_req && obs_n >= 1 && obs_n <= 48) req_cnt++;
      end
    end
    checks++;
    if (first_req !== 20) $display("FAIL toggle_first_req actual=%0d required=20", first_req);
    else passed++;
    checks++;
    if (req_cnt !== 12) $display("FAIL toggle_req_per_frame actual=%0d required=12", req_cnt);
    else passed++;
  endtask

  task automatic test_mid_reset();
    bit seen = 1'b0;
    int fs0 = -1, fs1 = -1, fs3 = -1;
    step(1'b1, 1'b1);
    for (int k = 0; k < 200 && !seen; k++) begin
      step(1'b1, 1'b0);
      if (o1_de) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL wait_active_line actual=timeout required=de");
    else passed++;
    step(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0);
      if (k == 0) begin
        checks++;
        if ({o1_de, o1_req, o1_x, o1_y, o1_hs, o1_vs, o3_de} !== {1'b0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0})
          $display("FAIL mid_reset_clear actual=%h required=%h",
                   {o1_de, o1_req, o1_x, o1_y, o1_hs, o1_vs, o3_de}, {1'b0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0});
        else passed++;
      end
      if (o0_fs && fs0 < 0) fs0 = obs_n;
      if (o1_fs && fs1 < 0) fs1 = obs_n;
      if (o3_fs && fs3 < 0) fs3 = obs_n;
    end
    checks++;
    if (fs1 !== 2) $display("FAIL frame_start_lead1 actual=%0d required=2", fs1);
    else passed++;
    checks++;
    if (fs0 !== 1) $display("FAIL frame_start_lead0 actual=%0d required=1", fs0);
    else passed++;
    checks++;
    if (fs3 !== 4) $display("FAIL frame_start_lead3 actual=%0d required=4", fs3);
    else passed++;
  endtask

  task automatic test_default_timing();
    int hs_low = 0, vs_low = 0, first_de = -1;
    logic [11:0] max_x = '0, last_y = '1;
    step(1'b1, 1'b1);
    for (int k = 0; k < 28800; k++) begin
      step(1'b1, 1'b0);
      if (obs_n >= 2 && obs_n <= 801 && !ob_hs) hs_low++;
      if (obs_n >= 2 && obs_n <= 4001 && !ob_vs) vs_low++;
      if (ob_de) begin
        if (first_de < 0) first_de = obs_n;
        if (ob_x > max_x) max_x = ob_x;
        last_y = ob_y;
      end
    end
    checks++;
    if (hs_low !== 96) $display("FAIL hsync_low_per_line actual=%0d required=96", hs_low);
    else passed++;
    checks++;
    if (vs_low !== 1600) $display("FAIL vsync_low_ticks actual=%0d required=1600", vs_low);
    else passed++;
    checks++;
    if (first_de !== 28146) $display("FAIL default_first_de actual=%0d required=28146", first_de);
    else passed++;
    checks++;
    if (max_x !== 12'd639) $display("FAIL default_last_x actual=%0d required=639", max_x);
    else passed++;
    checks++;
    if (last_y !== 12'd0) $display("FAIL default_first_line_y actual=%0d required=0", last_y);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_small_run();
    test_pix_en_toggle();
    test_mid_reset();
    test_default_timing();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
